if_prefetch: RTL

Parametrised instruction-fetch stage with a prefetch queue. It holds the fetch PC and issues sequential word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO feeding decode. A jump flushes the queue, redirects the PC and silently discards responses still in flight. The block sits between the PC/redirect logic of the pipeline and the decode stage.

---
 rtl/if_prefetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: fetch stage holding the PC, issuing sequential word fetches
// and buffering returned instructions with their PCs for decode.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   jump_flag_i/
//   jump_addr_i      redirect (flush queue, drop in-flight responses)
//   hold_i           stop issuing new requests only
//   req_*            fetch request channel (valid/ready)
//   resp_*           in-order instruction responses
//   inst_*, pc_o     head of queue to decode (valid/ready)
//   fetch_stall_o    queue empty while running
module if_prefetch #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned INST_W   = 32,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              resp_valid_i,
  input  logic [INST_W-1:0] resp_inst_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              inst_ready_i,
  output logic              fetch_stall_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [ADDR_W-1:0] RST_PC =
    RESET_PC[ADDR_W-1:0];
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     disc_q, disc_d;

  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic [ADDR_W-1:0] jump_tgt;
  logic [CW:0]       used;
  logic              credit;
  logic              req_fire;
  logic              not_empty;
  logic              enq;
  logic              drop;
  logic              deq;
  logic              unused_jmp_lsb;

  assign jump_tgt = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign unused_jmp_lsb = ^jump_addr_i[1:0];

  // Credit covers both buffered and in-flight
  // entries, so a response always has a slot.
  assign used   = {1'b0, count_q} + {1'b0, outst_q};
  assign credit = used < DEPTH_W;

  assign req_valid_o = rst_n & credit
                     & ~hold_i & ~jump_flag_i;
  assign req_addr_o  = fetch_pc_q;
  assign req_fire    = req_valid_o & req_ready_i;

  assign not_empty    = count_q != '0;
  assign inst_valid_o = not_empty & ~jump_flag_i;
  assign inst_o = not_empty ? inst_mem_q[rd_ptr_q] : '0;
  assign pc_o   = not_empty ? pc_mem_q[rd_ptr_q] : '0;
  assign fetch_stall_o = rst_n & ~not_empty;

  assign enq  = resp_valid_i & ~jump_flag_i
              & (disc_q == '0);
  assign drop = resp_valid_i & ~jump_flag_i
              & (disc_q != '0);
  assign deq  = inst_valid_o & inst_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    disc_d     = disc_q;
    outst_d    = outst_q + CW'(req_fire)
               - CW'(resp_valid_i);
    if (jump_flag_i) begin
      fetch_pc_d = jump_tgt;
      resp_pc_d  = jump_tgt;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still in flight after this
      // edge belongs to the old stream.
      disc_d     = outst_q - CW'(resp_valid_i);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (enq) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + STEP;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop) disc_d = disc_q - CW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (enq) begin
      inst_mem_q[wr_ptr_q] <= resp_inst_i;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule
